// File: rtl/demux1x8_32b_buf_if.sv
// Source/sink bundle for demux1x8_32b_buf: one valid/ready input word, eight buffered output lanes.
// Broadcast control (bcast) exists only when DEMUX8_BCAST_EN is defined.
interface demux1x8_32b_buf_if;
    logic [31:0] D;
    logic [2:0]  S;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Y0;
    logic [31:0] Y1;
    logic [31:0] Y2;
    logic [31:0] Y3;
    logic [31:0] Y4;
    logic [31:0] Y5;
    logic [31:0] Y6;
    logic [31:0] Y7;
    logic [7:0]  Y_valid;
    logic [7:0]  Y_ready;
`ifdef DEMUX8_BCAST_EN
    logic        bcast;

    modport master (
        output D, S, in_valid, Y_ready, bcast,
        input  in_ready, Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y_valid
    );
    modport slave (
        input  D, S, in_valid, Y_ready, bcast,
        output in_ready, Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y_valid
    );
`else
    modport master (
        output D, S, in_valid, Y_ready,
        input  in_ready, Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y_valid
    );
    modport slave (
        input  D, S, in_valid, Y_ready,
        output in_ready, Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y_valid
    );
`endif
endinterface

// File: rtl/demux1x8_32b_buf.sv
// 1-to-8 demultiplexer of 32-bit words into eight one-entry lane buffers with valid/ready on both sides.
// Optional broadcast to all lanes is compiled in with DEMUX8_BCAST_EN.
module demux1x8_32b_buf (
    input  logic                  clk,
    input  logic                  rst,
    demux1x8_32b_buf_if.slave     bus
);

    logic [31:0] y_q [8];
    logic [31:0] y_d [8];
    logic [7:0]  v_q;
    logic [7:0]  v_d;
    logic [7:0]  lane_free_s;
    logic [7:0]  wr_s;
    logic        in_ready_s;
    logic        push_s;

    // Acceptance decision and per-lane write enables.
    always_comb begin
        lane_free_s = ~v_q | bus.Y_ready;
        in_ready_s  = 1'b0;
        wr_s        = 8'h00;
`ifdef DEMUX8_BCAST_EN
        if (bus.bcast) begin
            // Broadcast is all-or-nothing: every lane must be able to take the word.
            in_ready_s = !rst && (&lane_free_s);
        end else begin
            in_ready_s = !rst && lane_free_s[bus.S];
        end
        push_s = bus.in_valid && in_ready_s;
        if (push_s && bus.bcast) begin
            wr_s = 8'hFF;
        end else if (push_s) begin
            wr_s = 8'h01 << bus.S;
        end else begin
            wr_s = 8'h00;
        end
`else
        in_ready_s = !rst && lane_free_s[bus.S];
        push_s     = bus.in_valid && in_ready_s;
        if (push_s) begin
            wr_s = 8'h01 << bus.S;
        end else begin
            wr_s = 8'h00;
        end
`endif
    end

    // Next lane state: a write wins over a pop on the same lane; data holds after a pop.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            y_d[i] = y_q[i];
            v_d[i] = v_q[i];
            if (wr_s[i]) begin
                y_d[i] = bus.D;
                v_d[i] = 1'b1;
            end else if (v_q[i] && bus.Y_ready[i]) begin
                v_d[i] = 1'b0;
            end else begin
                v_d[i] = v_q[i];
            end
        end
    end

    // Lane registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                y_q[i] <= 32'h0000_0000;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < 8; i++) begin
                y_q[i] <= y_d[i];
            end
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.Y_valid  = v_q;
    assign bus.Y0       = y_q[0];
    assign bus.Y1       = y_q[1];
    assign bus.Y2       = y_q[2];
    assign bus.Y3       = y_q[3];
    assign bus.Y4       = y_q[4];
    assign bus.Y5       = y_q[5];
    assign bus.Y6       = y_q[6];
    assign bus.Y7       = y_q[7];

endmodule
